// File: rtl/mac_hdr_parser_if.sv
// rtl/mac_hdr_parser_if.sv - byte stream in, learn/lookup request out, for mac_hdr_parser
interface mac_hdr_parser_if #(
    parameter int pNUM_PORTS  = 4,
    parameter int pADDR_WIDTH = 14
);
    localparam int PW = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;

    logic [PW-1:0]          ipnum;
    logic [7:0]             idata;
    logic                   ivalid;
    logic                   isof;
    logic                   ieof;
    logic                   iready;
    logic [pADDR_WIDTH-1:0] ida;
    logic [pADDR_WIDTH-1:0] isa;
    logic [PW-1:0]          opnum;
    logic                   owr_en;

    // master feeds bytes and accepts requests; slave is the parser
    modport master (
        output ipnum, idata, ivalid, isof, ieof, iready,
        input  ida, isa, opnum, owr_en
    );

    modport slave (
        input  ipnum, idata, ivalid, isof, ieof, iready,
        output ida, isa, opnum, owr_en
    );
endinterface

// File: rtl/mac_hdr_parser.sv
// rtl/mac_hdr_parser.sv - DA/SA capture, XOR-fold hash, one-deep learn/lookup request slot
// Optional: MAC_HDR_MCAST_FILTER_EN rejects headers whose SA has the group bit set.
module mac_hdr_parser #(
    parameter int pNUM_PORTS  = 4,
    parameter int pADDR_WIDTH = 14
) (
    input  logic              iclk,
    input  logic              irst,
    mac_hdr_parser_if.slave   bus,
    output logic              orunt,
    output logic              odrop
);
    localparam int PW = (pNUM_PORTS > 1) ? $clog2(pNUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, HDR, SKIP} state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [87:0]            hdr_q;
    logic [PW-1:0]          pnum_q;
    logic                   owr_en_q;
    logic [pADDR_WIDTH-1:0] ida_q;
    logic [pADDR_WIDTH-1:0] isa_q;
    logic [PW-1:0]          opnum_q;
    logic                   orunt_q;
    logic                   odrop_q;

    logic [95:0]            hdr_d;
    logic                   accept;
    logic                   sa_block;

    function automatic logic [pADDR_WIDTH-1:0] fold(input logic [47:0] m);
        logic [pADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < 48; i += pADDR_WIDTH)
            r = r ^ pADDR_WIDTH'(m >> i);
        return r;
    endfunction

    // Header as it stands once the current byte is included: DA in [95:48], SA in [47:0]
    assign hdr_d  = {hdr_q, bus.idata};
    assign accept = owr_en_q & bus.iready;

`ifdef MAC_HDR_MCAST_FILTER_EN
    assign sa_block = hdr_d[40];
`else
    assign sa_block = 1'b0;
`endif

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hdr_q    <= '0;
            pnum_q   <= '0;
            owr_en_q <= 1'b0;
            ida_q    <= '0;
            isa_q    <= '0;
            opnum_q  <= '0;
            orunt_q  <= 1'b0;
            odrop_q  <= 1'b0;
        end else begin
            orunt_q <= 1'b0;
            odrop_q <= 1'b0;
            if (accept)
                owr_en_q <= 1'b0;

            if (bus.ivalid) begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.isof && !bus.ieof) begin
                            pnum_q  <= bus.ipnum;
                            cnt_q   <= 4'd1;
                            hdr_q   <= hdr_d[87:0];
                            state_q <= HDR;
                        end
                    end
                    HDR: begin
                        if (bus.isof) begin
                            orunt_q <= 1'b1;
                            if (bus.ieof) begin
                                state_q <= IDLE;
                            end else begin
                                pnum_q <= bus.ipnum;
                                cnt_q  <= 4'd1;
                                hdr_q  <= hdr_d[87:0];
                            end
                        end else if (cnt_q == 4'd11) begin
                            cnt_q   <= 4'd12;
                            state_q <= bus.ieof ? IDLE : SKIP;
                            // Slot may reload in the same cycle it is being accepted
                            if (sa_block || (owr_en_q && !accept)) begin
                                odrop_q <= 1'b1;
                            end else begin
                                owr_en_q <= 1'b1;
                                ida_q    <= fold(hdr_d[95:48]);
                                isa_q    <= fold(hdr_d[47:0]);
                                opnum_q  <= pnum_q;
                            end
                        end else if (bus.ieof) begin
                            orunt_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            hdr_q <= hdr_d[87:0];
                        end
                    end
                    SKIP: begin
                        if (bus.isof && !bus.ieof) begin
                            pnum_q  <= bus.ipnum;
                            cnt_q   <= 4'd1;
                            hdr_q   <= hdr_d[87:0];
                            state_q <= HDR;
                        end else if (bus.ieof) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.owr_en = owr_en_q;
    assign bus.ida    = ida_q;
    assign bus.isa    = isa_q;
    assign bus.opnum  = opnum_q;
    assign orunt      = orunt_q;
    assign odrop      = odrop_q;
endmodule

// File: tb/tb_mac_hdr_parser.sv
// tb/tb_mac_hdr_parser.sv - directed self-checking bench for mac_hdr_parser
module tb_mac_hdr_parser;
    logic iclk = 1'b0;
    logic irst;
    logic orunt;
    logic odrop;

    mac_hdr_parser_if #(.pNUM_PORTS(4), .pADDR_WIDTH(14)) bus();

    mac_hdr_parser #(.pNUM_PORTS(4), .pADDR_WIDTH(14)) dut (
        .iclk  (iclk),
        .irst  (irst),
        .bus   (bus),
        .orunt (orunt),
        .odrop (odrop)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_wr     = 0;

    task automatic drive(input logic [7:0] b, input logic s, input logic e, input logic v);
        bus.idata  = b;
        bus.isof   = s;
        bus.ieof   = e;
        bus.ivalid = v;
        if (bus.owr_en && bus.iready) n_acc++;
        @(posedge iclk);
        #1;
        if (bus.owr_en) n_wr++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] hbyte(input logic [47:0] da, input logic [47:0] sa, input int i);
        if (i < 6) return da[47-8*i -: 8];
        return sa[47-8*(i-6) -: 8];
    endfunction

    task automatic send_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] port,
                            input int first, input int last, input logic eof_last);
        bus.ipnum = port;
        for (int i = first; i <= last; i++)
            drive(hbyte(da, sa, i), i == 0, eof_last && (i == last), 1'b1);
    endtask

    task automatic test_reset;
        irst = 1'b1;
        idle(3);
        irst = 1'b0;
        idle(1);
        n_checks++; if (bus.ida !== 14'h0) begin n_fail++; $display("FAIL reset_ida got %h exp 0", bus.ida); end
        n_checks++; if (bus.isa !== 14'h0) begin n_fail++; $display("FAIL reset_isa got %h exp 0", bus.isa); end
        n_checks++; if (bus.opnum !== 2'd0) begin n_fail++; $display("FAIL reset_opnum got %h exp 0", bus.opnum); end
        n_checks++; if (bus.owr_en !== 1'b0) begin n_fail++; $display("FAIL reset_owr_en got %b exp 0", bus.owr_en); end
        n_checks++; if (orunt !== 1'b0) begin n_fail++; $display("FAIL reset_orunt got %b exp 0", orunt); end
        n_checks++; if (odrop !== 1'b0) begin n_fail++; $display("FAIL reset_odrop got %b exp 0", odrop); end
    endtask

    task automatic test_basic;
        bus.iready = 1'b1;
        n_wr = 0; n_acc = 0;
        send_hdr(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 2'd2, 0, 10, 1'b0);
        n_checks++; if (bus.owr_en !== 1'b0) begin n_fail++; $display("FAIL basic_early_wr got %b exp 0", bus.owr_en); end
        send_hdr(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 2'd2, 11, 11, 1'b0);
        n_checks++; if (bus.owr_en !== 1'b1) begin n_fail++; $display("FAIL basic_wr got %b exp 1", bus.owr_en); end
        n_checks++; if (bus.ida !== 14'h3FC0) begin n_fail++; $display("FAIL basic_ida got %h exp 3fc0", bus.ida); end
        n_checks++; if (bus.isa !== 14'h0D8A) begin n_fail++; $display("FAIL basic_isa got %h exp 0d8a", bus.isa); end
        n_checks++; if (bus.opnum !== 2'd2) begin n_fail++; $display("FAIL basic_opnum got %h exp 2", bus.opnum); end
        for (int i = 12; i < 64; i++) drive(8'(i), 1'b0, i == 63, 1'b1);
        n_checks++; if (n_wr !== 1) begin n_fail++; $display("FAIL basic_wr_cycles got %0d exp 1", n_wr); end
        n_checks++; if (n_acc !== 1) begin n_fail++; $display("FAIL basic_accepts got %0d exp 1", n_acc); end
        n_checks++; if (bus.ida !== 14'h3FC0) begin n_fail++; $display("FAIL basic_ida_hold got %h exp 3fc0", bus.ida); end
    endtask

    task automatic test_backpressure;
        bus.iready = 1'b0;
        idle(1);
        n_wr = 0; n_acc = 0;
        send_hdr(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 2'd2, 0, 11, 1'b0);
        for (int i = 12; i < 64; i++) begin
            if (i == 17) bus.iready = 1'b1;
            drive(8'(i), 1'b0, i == 63, 1'b1);
            if (i < 17) begin
                n_checks++;
                if (bus.owr_en !== 1'b1 || bus.ida !== 14'h3FC0 || bus.isa !== 14'h0D8A || bus.opnum !== 2'd2) begin
                    n_fail++;
                    $display("FAIL bp_hold byte %0d got wr=%b da=%h sa=%h pn=%h exp 1/3fc0/0d8a/2",
                             i, bus.owr_en, bus.ida, bus.isa, bus.opnum);
                end
            end
        end
        n_checks++; if (n_wr !== 6) begin n_fail++; $display("FAIL bp_wr_cycles got %0d exp 6", n_wr); end
        n_checks++; if (n_acc !== 1) begin n_fail++; $display("FAIL bp_accepts got %0d exp 1", n_acc); end
    endtask

    task automatic test_runt;
        bus.iready = 1'b1;
        n_wr = 0;
        send_hdr(48'hAAAA_BBBB_CCCC, 48'h1234_5678_9ABC, 2'd3, 0, 7, 1'b1);
        n_checks++; if (orunt !== 1'b1) begin n_fail++; $display("FAIL runt_pulse got %b exp 1", orunt); end
        idle(1);
        n_checks++; if (orunt !== 1'b0) begin n_fail++; $display("FAIL runt_pulse_end got %b exp 0", orunt); end
        n_checks++; if (n_wr !== 0) begin n_fail++; $display("FAIL runt_no_wr got %0d exp 0", n_wr); end
        send_hdr(48'h1, 48'h5, 2'd1, 0, 11, 1'b1);
        n_checks++; if (bus.owr_en !== 1'b1) begin n_fail++; $display("FAIL runt_next_wr got %b exp 1", bus.owr_en); end
        n_checks++; if (bus.ida !== 14'h1 || bus.isa !== 14'h5 || bus.opnum !== 2'd1) begin
            n_fail++; $display("FAIL runt_next_vals got %h/%h/%h exp 0001/0005/1", bus.ida, bus.isa, bus.opnum); end
        idle(2);
    endtask

    task automatic test_back_to_back;
        bus.iready = 1'b0;
        send_hdr(48'h1, 48'h2, 2'd0, 0, 11, 1'b1);
        n_checks++; if (bus.owr_en !== 1'b1 || bus.ida !== 14'h1) begin
            n_fail++; $display("FAIL b2b_first got wr=%b da=%h exp 1/0001", bus.owr_en, bus.ida); end
        send_hdr(48'h3, 48'h4, 2'd3, 0, 11, 1'b1);
        n_checks++; if (odrop !== 1'b1) begin n_fail++; $display("FAIL b2b_drop got %b exp 1", odrop); end
        n_checks++; if (bus.owr_en !== 1'b1 || bus.ida !== 14'h1 || bus.isa !== 14'h2 || bus.opnum !== 2'd0) begin
            n_fail++; $display("FAIL b2b_retain got %b/%h/%h/%h exp 1/0001/0002/0", bus.owr_en, bus.ida, bus.isa, bus.opnum); end
        idle(1);
        n_checks++; if (odrop !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_end got %b exp 0", odrop); end
        bus.iready = 1'b1;
        idle(1);
        n_checks++; if (bus.owr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got %b exp 0", bus.owr_en); end

        bus.iready = 1'b0;
        n_acc = 0;
        send_hdr(48'h1, 48'h2, 2'd0, 0, 11, 1'b1);
        send_hdr(48'h3, 48'h4, 2'd3, 0, 10, 1'b0);
        bus.iready = 1'b1;
        send_hdr(48'h3, 48'h4, 2'd3, 11, 11, 1'b1);
        n_checks++; if (bus.owr_en !== 1'b1 || bus.ida !== 14'h3 || bus.isa !== 14'h4 || bus.opnum !== 2'd3) begin
            n_fail++; $display("FAIL b2b_reload got %b/%h/%h/%h exp 1/0003/0004/3", bus.owr_en, bus.ida, bus.isa, bus.opnum); end
        n_checks++; if (odrop !== 1'b0) begin n_fail++; $display("FAIL b2b_reload_drop got %b exp 0", odrop); end
        n_checks++; if (n_acc !== 1) begin n_fail++; $display("FAIL b2b_acc1 got %0d exp 1", n_acc); end
        idle(1);
        n_checks++; if (bus.owr_en !== 1'b0 || n_acc !== 2) begin
            n_fail++; $display("FAIL b2b_acc2 got wr=%b acc=%0d exp 0/2", bus.owr_en, n_acc); end
    endtask

    task automatic test_restart_and_reset;
        bus.iready = 1'b1;
        send_hdr(48'hAAAA_AAAA_AAAA, 48'hBBBB_BBBB_BBBB, 2'd1, 0, 4, 1'b0);
        send_hdr(48'h7, 48'h9, 2'd2, 0, 0, 1'b0);
        n_checks++; if (orunt !== 1'b1) begin n_fail++; $display("FAIL restart_runt got %b exp 1", orunt); end
        send_hdr(48'h7, 48'h9, 2'd1, 1, 11, 1'b0);
        n_checks++; if (bus.owr_en !== 1'b1 || bus.ida !== 14'h7 || bus.isa !== 14'h9 || bus.opnum !== 2'd2) begin
            n_fail++; $display("FAIL restart_req got %b/%h/%h/%h exp 1/0007/0009/2", bus.owr_en, bus.ida, bus.isa, bus.opnum); end
        drive(8'h00, 1'b0, 1'b1, 1'b1);
        idle(1);

        send_hdr(48'h5, 48'h6, 2'd3, 0, 8, 1'b0);
        #2 irst = 1'b1;
        #1;
        n_checks++; if (bus.ida !== 14'h0 || bus.isa !== 14'h0 || bus.opnum !== 2'd0 || bus.owr_en !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got %h/%h/%h/%b exp 0/0/0/0", bus.ida, bus.isa, bus.opnum, bus.owr_en); end
        @(posedge iclk);
        #1 irst = 1'b0;
        n_wr = 0;
        send_hdr(48'h5, 48'h6, 2'd3, 9, 11, 1'b1);
        idle(1);
        n_checks++; if (n_wr !== 0 || orunt !== 1'b0 || odrop !== 1'b0) begin
            n_fail++; $display("FAIL reset_partial got wr=%0d runt=%b drop=%b exp 0/0/0", n_wr, orunt, odrop); end
    endtask

    task automatic test_skip_and_one_byte;
        bus.iready = 1'b1;
        n_wr = 0;
        drive(8'h55, 1'b1, 1'b1, 1'b1);
        n_checks++; if (orunt !== 1'b0) begin n_fail++; $display("FAIL idle_1byte_runt got %b exp 0", orunt); end
        send_hdr(48'h11, 48'h22, 2'd3, 0, 11, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'h55, 1'b1, 1'b1, 1'b1);
        n_checks++; if (orunt !== 1'b0) begin n_fail++; $display("FAIL skip_1byte_runt got %b exp 0", orunt); end
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        send_hdr(48'h33, 48'h44, 2'd1, 0, 0, 1'b0);
        n_checks++; if (orunt !== 1'b0) begin n_fail++; $display("FAIL skip_restart_runt got %b exp 0", orunt); end
        send_hdr(48'h33, 48'h44, 2'd0, 1, 11, 1'b1);
        n_checks++; if (bus.owr_en !== 1'b1 || bus.ida !== 14'h33 || bus.isa !== 14'h44 || bus.opnum !== 2'd1) begin
            n_fail++; $display("FAIL skip_restart_req got %b/%h/%h/%h exp 1/0033/0044/1", bus.owr_en, bus.ida, bus.isa, bus.opnum); end
        idle(1);
        send_hdr(48'h33, 48'h44, 2'd1, 0, 2, 1'b0);
        drive(8'h55, 1'b1, 1'b1, 1'b1);
        n_checks++; if (orunt !== 1'b1) begin n_fail++; $display("FAIL hdr_1byte_runt got %b exp 1", orunt); end
        idle(1);
        n_checks++; if (orunt !== 1'b0 || n_wr !== 2) begin
            n_fail++; $display("FAIL hdr_1byte_once got runt=%b wr=%0d exp 0/2", orunt, n_wr); end
    endtask

    task automatic test_mcast;
        bus.iready = 1'b1;
        idle(1);
        send_hdr(48'h1, 48'h0100_5E00_0001, 2'd2, 0, 11, 1'b1);
`ifdef MAC_HDR_MCAST_FILTER_EN
        n_checks++; if (odrop !== 1'b1) begin n_fail++; $display("FAIL mcast_drop got %b exp 1", odrop); end
        n_checks++; if (bus.owr_en !== 1'b0) begin n_fail++; $display("FAIL mcast_no_wr got %b exp 0", bus.owr_en); end
`else
        n_checks++; if (odrop !== 1'b0) begin n_fail++; $display("FAIL mcast_drop got %b exp 0", odrop); end
        n_checks++; if (bus.owr_en !== 1'b1 || bus.isa !== 14'h2804 || bus.ida !== 14'h1) begin
            n_fail++; $display("FAIL mcast_req got %b/%h/%h exp 1/0001/2804", bus.owr_en, bus.ida, bus.isa); end
`endif
        idle(2);
    endtask

    initial begin
        bus.ipnum  = '0;
        bus.idata  = '0;
        bus.ivalid = 1'b0;
        bus.isof   = 1'b0;
        bus.ieof   = 1'b0;
        bus.iready = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_runt;
        test_back_to_back;
        test_restart_and_reset;
        test_skip_and_one_byte;
        test_mcast;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
